// File: rtl/totient_seq_display.sv
// ---------------------------------------------------------------------------
// totient_seq_display
//
// Walks n through 1..N_MAX (wrapping back to 1) and computes Euler's totient
// phi(n) at run time by counting the k in 1..n with gcd(k, n) == 1.  Each gcd
// is found by repeated subtraction, one subtraction per clock.  The last
// completed phi is shown on a multiplexed hex 7-segment display.
//
// Optional feature macro: BLANK_LEAD_ZERO_EN
//   defined   - digits above the most-significant non-zero nibble of phi_out
//               are blanked (digit 0 is always lit)
//   undefined - every digit shows its nibble, leading zeros included
//
// Ports
//   clk_0      in   sole clock, rising edge
//   R          in   asynchronous reset, active-high
//   run        in   1 = auto-advance after HOLD_CYCLES, 0 = advance on step
//   step       in   manual advance request, level-sampled while waiting
//   A..G       out  segments, active-high (combinational decode of registers)
//   dig_sel    out  one-hot digit enable, bit0 = least-significant nibble
//   n_out      out  current n
//   phi_out    out  phi of the last completed n
//   phi_valid  out  phi_out belongs to n_out
//   busy       out  computation in progress
// ---------------------------------------------------------------------------
module totient_seq_display #(
    parameter int W           = 8,
    parameter int N_MAX       = 255,
    parameter int HOLD_CYCLES = 50000000,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                 clk_0,
    input  logic                 R,
    input  logic                 run,
    input  logic                 step,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    output logic                 D,
    output logic                 E,
    output logic                 F,
    output logic                 G,
    output logic [(W+3)/4-1:0]   dig_sel,
    output logic [W-1:0]         n_out,
    output logic [W-1:0]         phi_out,
    output logic                 phi_valid,
    output logic                 busy
);
    localparam int DIGITS = (W + 3) / 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [W-1:0]      N_LAST    = W'(N_MAX);
    localparam logic [W-1:0]      N_ONE     = W'(1);
    localparam logic [W:0]        K_ONE     = {{W{1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] DIG_ONE   = DIGITS'(1);

    typedef enum logic [2:0] {
        S_START,
        S_LOAD,
        S_GCD,
        S_CHECK,
        S_DONE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        n_q, n_d;
    logic [W:0]          k_q, k_d;
    logic [W:0]          cnt_q, cnt_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        phi_q, phi_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                advance;

    logic [4*DIGITS-1:0] phi_ext;
    logic [3:0]          nibble;
    logic [6:0]          seg;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1111110;
            4'h1:    hex7 = 7'b0110000;
            4'h2:    hex7 = 7'b1101101;
            4'h3:    hex7 = 7'b1111001;
            4'h4:    hex7 = 7'b0110011;
            4'h5:    hex7 = 7'b1011011;
            4'h6:    hex7 = 7'b1011111;
            4'h7:    hex7 = 7'b1110000;
            4'h8:    hex7 = 7'b1111111;
            4'h9:    hex7 = 7'b1111011;
            4'hA:    hex7 = 7'b1110111;
            4'hB:    hex7 = 7'b0011111;
            4'hC:    hex7 = 7'b1001110;
            4'hD:    hex7 = 7'b0111101;
            4'hE:    hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    // Totient FSM next state.  The hold counter only counts while run is
    // high so a run toggle pauses the hold rather than restarting it.
    // phi_valid drops on the advance itself so it never pairs a new n
    // with the old phi.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        phi_d   = phi_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        advance = 1'b0;
        case (state_q)
            S_START: begin
                k_d     = K_ONE;
                cnt_d   = '0;
                busy_d  = 1'b1;
                valid_d = 1'b0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                a_d     = k_q[W-1:0];
                b_d     = n_q;
                state_d = S_GCD;
            end
            S_GCD: begin
                if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else if (b_q > a_q) begin
                    b_d = b_q - a_q;
                end else begin
                    if (a_q == N_ONE) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    k_d     = k_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = (k_q > {1'b0, n_q}) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                // cnt never exceeds n, so the top bit is only a guard.
                phi_d   = cnt_q[W] ? {W{1'b1}} : cnt_q[W-1:0];
                valid_d = 1'b1;
                busy_d  = 1'b0;
                hold_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                advance = run ? (hold_q == HOLD_LAST) : step;
                if (run && !advance) begin
                    hold_d = hold_q + 1'b1;
                end
                if (advance) begin
                    n_d     = (n_q == N_LAST) ? N_ONE : n_q + 1'b1;
                    valid_d = 1'b0;
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase
    end

    // Digit scan: each digit stays selected for SCAN_DIV cycles.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        dig_sel_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_sel_d[i] = (idx_d == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_0 or posedge R) begin
        if (R) begin
            state_q   <= S_START;
            n_q       <= N_ONE;
            k_q       <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            phi_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            dig_sel_q <= DIG_ONE;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            phi_q     <= phi_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            hold_q    <= hold_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    // Zero-extend phi so every digit has a full nibble to decode.
    always_comb begin
        phi_ext        = '0;
        phi_ext[W-1:0] = phi_q;
        nibble         = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = phi_ext[4*i +: 4];
            end
        end
    end

`ifdef BLANK_LEAD_ZERO_EN
    // A digit is lit if it is digit 0 or any nibble at or above it is non-zero.
    logic show_digit;
    always_comb begin
        show_digit = (idx_q == '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (phi_ext[4*i +: 4] != 4'h0)) begin
                show_digit = 1'b1;
            end
        end
    end
    assign seg = show_digit ? hex7(nibble) : 7'b0000000;
`else
    assign seg = hex7(nibble);
`endif

    assign {A, B, C, D, E, F, G} = seg;
    assign dig_sel   = dig_sel_q;
    assign n_out     = n_q;
    assign phi_out   = phi_q;
    assign phi_valid = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_totient_seq_display.sv
// ---------------------------------------------------------------------------
// tb_totient_seq_display
//
// Three instances share one clock.  dut1 and dut3 (N_MAX=255) share run and
// step so they stay in lockstep; dut3 additionally has its own reset so it
// can be killed mid-computation while dut1 finishes the same n.  dut2 uses
// N_MAX=15 for the wrap checks.
// ---------------------------------------------------------------------------
module tb_totient_seq_display;

    logic clk;
    logic rst;
    logic kill3;
    logic rst3;
    logic run;
    logic step;
    logic run2;
    logic step2;

    logic [6:0] seg1, seg2, seg3;
    logic [1:0] dig1, dig2, dig3;
    logic [7:0] n1, n2, n3;
    logic [7:0] phi1, phi2, phi3;
    logic       v1, v2, v3;
    logic       busy1, busy2, busy3;

    int compared;
    int mismatched;

    assign rst3 = rst | kill3;

    totient_seq_display #(.W(8), .N_MAX(255), .HOLD_CYCLES(20), .SCAN_DIV(4)) dut1 (
        .clk_0(clk), .R(rst), .run(run), .step(step),
        .A(seg1[6]), .B(seg1[5]), .C(seg1[4]), .D(seg1[3]),
        .E(seg1[2]), .F(seg1[1]), .G(seg1[0]),
        .dig_sel(dig1), .n_out(n1), .phi_out(phi1),
        .phi_valid(v1), .busy(busy1)
    );

    totient_seq_display #(.W(8), .N_MAX(15), .HOLD_CYCLES(20), .SCAN_DIV(4)) dut2 (
        .clk_0(clk), .R(rst), .run(run2), .step(step2),
        .A(seg2[6]), .B(seg2[5]), .C(seg2[4]), .D(seg2[3]),
        .E(seg2[2]), .F(seg2[1]), .G(seg2[0]),
        .dig_sel(dig2), .n_out(n2), .phi_out(phi2),
        .phi_valid(v2), .busy(busy2)
    );

    totient_seq_display #(.W(8), .N_MAX(255), .HOLD_CYCLES(20), .SCAN_DIV(4)) dut3 (
        .clk_0(clk), .R(rst3), .run(run), .step(step),
        .A(seg3[6]), .B(seg3[5]), .C(seg3[4]), .D(seg3[3]),
        .E(seg3[2]), .F(seg3[1]), .G(seg3[0]),
        .dig_sel(dig3), .n_out(n3), .phi_out(phi3),
        .phi_valid(v3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until the selected instance reports phi_valid.
    task automatic wait_valid(input int which, input int limit);
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ((which == 1 && v1) || (which == 2 && v2) || (which == 3 && v3)) break;
        end
    endtask

    // Wait (bounded) until the selected instance selects the given digit.
    task automatic wait_digit(input int which, input logic [1:0] sel);
        for (int c = 0; c < 16; c++) begin
            if ((which == 1 && dig1 == sel) || (which == 2 && dig2 == sel)) break;
            @(negedge clk);
        end
    endtask

    task automatic step_once(input int which);
        @(negedge clk);
        if (which == 2) step2 = 1'b1; else step = 1'b1;
        @(negedge clk);
        step  = 1'b0;
        step2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        run = 0; step = 0; run2 = 0; step2 = 0; kill3 = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (n1 !== 8'd1) begin mismatched++; $display("[TB] FAIL reset_n: got %0d expected 1", n1); end
        compared++;
        if (phi1 !== 8'd0 || v1 !== 1'b0 || busy1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_flags: phi=%0d valid=%b busy=%b expected 0/0/0", phi1, v1, busy1);
        end
        compared++;
        if (dig1 !== 2'b01 || seg1 !== 7'b1111110) begin
            mismatched++; $display("[TB] FAIL reset_display: dig=%b seg=%b expected 01/1111110", dig1, seg1);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (busy1 !== 1'b1 || v1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL busy_rise: busy=%b valid=%b expected 1/0", busy1, v1);
        end
        wait_valid(1, 200);
        compared++;
        if (v1 !== 1'b1 || phi1 !== 8'd1 || n1 !== 8'd1) begin
            mismatched++; $display("[TB] FAIL phi_of_1: valid=%b phi=%0d n=%0d expected 1/1/1", v1, phi1, n1);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (n1 !== 8'd1 || v1 !== 1'b1 || busy1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL wait_hold: n=%0d valid=%b busy=%b expected 1/1/0", n1, v1, busy1);
        end
    endtask

    task automatic test_step_sequence();
        int exp_phi [11] = '{1, 2, 2, 4, 2, 6, 4, 6, 4, 10, 4};
        logic [7:0] prev;
        for (int i = 0; i < 11; i++) begin
            prev = phi1;
            step_once(1);
            compared++;
            if (v1 !== 1'b0 || phi1 !== prev) begin
                mismatched++; $display("[TB] FAIL busy_keeps_phi: valid=%b phi=%0d expected 0/%0d", v1, phi1, prev);
            end
            wait_valid(1, 2000);
            compared++;
            if (v1 !== 1'b1 || n1 !== 8'(i + 2) || phi1 !== 8'(exp_phi[i])) begin
                mismatched++;
                $display("[TB] FAIL phi_seq: valid=%b n=%0d phi=%0d expected 1/%0d/%0d", v1, n1, phi1, i + 2, exp_phi[i]);
            end
        end
        wait_digit(1, 2'b01);
        compared++;
        if (dig1 !== 2'b01 || seg1 !== 7'b0110011) begin
            mismatched++; $display("[TB] FAIL digit0_n12: dig=%b seg=%b expected 01/0110011", dig1, seg1);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp_hi;
`ifdef BLANK_LEAD_ZERO_EN
        exp_hi = 7'b0000000;
`else
        exp_hi = 7'b1111110;
`endif
        for (int n = 2; n <= 15; n++) begin
            step_once(2);
            wait_valid(2, 2000);
            compared++;
            if (v2 !== 1'b1 || n2 !== 8'(n)) begin
                mismatched++; $display("[TB] FAIL wrap_walk: valid=%b n=%0d expected 1/%0d", v2, n2, n);
            end
            if (n == 7) begin
                wait_digit(2, 2'b10);
                compared++;
                if (dig2 !== 2'b10 || seg2 !== exp_hi) begin
                    mismatched++; $display("[TB] FAIL lead_digit_n7: dig=%b seg=%b expected 10/%b", dig2, seg2, exp_hi);
                end
                wait_digit(2, 2'b01);
                compared++;
                if (dig2 !== 2'b01 || seg2 !== 7'b1011111) begin
                    mismatched++; $display("[TB] FAIL digit0_n7: dig=%b seg=%b expected 01/1011111", dig2, seg2);
                end
            end
        end
        compared++;
        if (phi2 !== 8'd8) begin mismatched++; $display("[TB] FAIL phi_15: got %0d expected 8", phi2); end
        step_once(2);
        wait_valid(2, 200);
        compared++;
        if (v2 !== 1'b1 || n2 !== 8'd1 || phi2 !== 8'd1) begin
            mismatched++; $display("[TB] FAIL wrap_to_1: valid=%b n=%0d phi=%0d expected 1/1/1", v2, n2, phi2);
        end
        step2 = 1'b1;
        wait_valid(2, 500);
        compared++;
        if (v2 !== 1'b1 || n2 !== 8'd2 || phi2 !== 8'd1) begin
            mismatched++; $display("[TB] FAIL held_step_first: n=%0d phi=%0d expected 2/1", n2, phi2);
        end
        @(negedge clk);
        compared++;
        if (n2 !== 8'd3 || v2 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL held_step_once: n=%0d valid=%b expected 3/0", n2, v2);
        end
        wait_valid(2, 500);
        step2 = 1'b0;
        compared++;
        if (v2 !== 1'b1 || n2 !== 8'd3 || phi2 !== 8'd2) begin
            mismatched++; $display("[TB] FAIL held_step_second: n=%0d phi=%0d expected 3/2", n2, phi2);
        end
        repeat (10) @(negedge clk);
        compared++;
        if (n2 !== 8'd3 || v2 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL step_release: n=%0d valid=%b expected 3/1", n2, v2);
        end
    endtask

    task automatic test_auto_run();
        int c;
        run = 1'b1;
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            wait_valid(1, 500);
            c = 0;
            while (n1 == 8'(rep + 1) && c < 100) begin
                @(negedge clk);
                c++;
            end
            compared++;
            if (c != 20 || n1 !== 8'(rep + 2)) begin
                mismatched++; $display("[TB] FAIL auto_hold: cycles=%0d n=%0d expected 20/%0d", c, n1, rep + 2);
            end
        end
        wait_valid(1, 500);
        repeat (5) @(negedge clk);
        run = 1'b0;
        repeat (30) @(negedge clk);
        compared++;
        if (n1 !== 8'd3 || v1 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL run_freeze: n=%0d valid=%b expected 3/1", n1, v1);
        end
        step_once(1);
        compared++;
        if (n1 !== 8'd4 || v1 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL freeze_step: n=%0d valid=%b expected 4/0", n1, v1);
        end
    endtask

    task automatic test_reset_busy();
        run = 1'b0;
        do_reset();
        wait_valid(1, 200);
        step = 1'b1;
        for (int c = 0; c < 90000; c++) begin
            @(negedge clk);
            if (n1 == 8'd96) break;
        end
        step = 1'b0;
        wait_valid(1, 5000);
        compared++;
        if (v1 !== 1'b1 || n1 !== 8'd96 || phi1 !== 8'd32) begin
            mismatched++; $display("[TB] FAIL phi_96: valid=%b n=%0d phi=%0d expected 1/96/32", v1, n1, phi1);
        end
        step_once(1);
        repeat (3) @(negedge clk);
        compared++;
        if (busy3 !== 1'b1 || n3 !== 8'd97) begin
            mismatched++; $display("[TB] FAIL busy_97: busy=%b n=%0d expected 1/97", busy3, n3);
        end
        kill3 = 1'b1;
        #1;
        compared++;
        if (n3 !== 8'd1 || v3 !== 1'b0 || dig3 !== 2'b01) begin
            mismatched++; $display("[TB] FAIL async_reset: n=%0d valid=%b dig=%b expected 1/0/01", n3, v3, dig3);
        end
        compared++;
        if (busy3 !== 1'b0 || phi3 !== 8'd0) begin
            mismatched++; $display("[TB] FAIL async_reset_phi: busy=%b phi=%0d expected 0/0", busy3, phi3);
        end
        @(negedge clk);
        kill3 = 1'b0;
        wait_valid(3, 200);
        compared++;
        if (v3 !== 1'b1 || n3 !== 8'd1 || phi3 !== 8'd1) begin
            mismatched++; $display("[TB] FAIL restart_phi1: valid=%b n=%0d phi=%0d expected 1/1/1", v3, n3, phi3);
        end
    endtask

    task automatic test_scan();
        logic stable;
        wait_valid(1, 5000);
        compared++;
        if (v1 !== 1'b1 || n1 !== 8'd97 || phi1 !== 8'd96) begin
            mismatched++; $display("[TB] FAIL phi_97: valid=%b n=%0d phi=%0d expected 1/97/96", v1, n1, phi1);
        end
        wait_digit(1, 2'b10);
        wait_digit(1, 2'b01);
        compared++;
        if (dig1 !== 2'b01 || seg1 !== 7'b1111110) begin
            mismatched++; $display("[TB] FAIL scan_digit0: dig=%b seg=%b expected 01/1111110", dig1, seg1);
        end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (dig1 !== 2'b01) stable = 1'b0;
        end
        compared++;
        if (stable !== 1'b1) begin
            mismatched++; $display("[TB] FAIL scan_dwell: digit0 held=%b expected 1", stable);
        end
        @(negedge clk);
        compared++;
        if (dig1 !== 2'b10 || seg1 !== 7'b1011111) begin
            mismatched++; $display("[TB] FAIL scan_digit1: dig=%b seg=%b expected 10/1011111", dig1, seg1);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        kill3 = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        run2  = 1'b0;
        step2 = 1'b0;
        test_reset();
        test_step_sequence();
        test_wrap();
        test_auto_run();
        test_reset_busy();
        test_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
